// File: rtl/hsv_core_regfile_sb.sv
// rtl/hsv_core_regfile_sb.sv - register file with per-register reservation scoreboard
// Multi-port combinational reads, one write-back port, one reservation port and flush.
module hsv_core_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk_core,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_valid,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_valid,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_ready,
    input  logic                       flush
);

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_wr_en;
    logic                w_rsv_take;

    assign w_wr_en    = wr_valid && (wr_addr != '0);
    assign rsv_ready  = !flush && ((rsv_addr == '0) || !r_busy[rsv_addr] ||
                                   (wr_valid && (wr_addr == rsv_addr)));
    assign w_rsv_take = rsv_valid && rsv_ready && (rsv_addr != '0);

    // Reservation set is applied after the write-back clear so a new reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_rsv_take) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_byp;

        assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];
        assign w_byp  = (BYPASS != 0) && wr_valid && (wr_addr == w_addr);
        assign rd_data[g*DATA_W +: DATA_W] = (w_addr == '0) ? '0 :
                                             w_byp          ? wr_data : r_mem[w_addr];
        assign rd_busy[g] = (w_addr != '0) && !w_byp && r_busy[w_addr];
    end

endmodule

// File: tb/tb_hsv_core_regfile_sb.sv
// tb/tb_hsv_core_regfile_sb.sv - self-checking bench for hsv_core_regfile_sb
module tb_hsv_core_regfile_sb;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int CAW = 4;
    localparam int CDW = 64;
    localparam int CNR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Shared stimulus for the two default-size instances (bypass on / off)
    logic            rst = 1'b1;
    logic            wr_valid = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            rsv_valid = 1'b0;
    logic [AW-1:0]   rsv_addr = '0;
    logic            flush = 1'b0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] a_rd_data, b_rd_data;
    logic [1:0]      a_rd_busy, b_rd_busy;
    logic            a_rsv_ready, b_rsv_ready;

    // Stimulus for the wide 4-port instance
    logic              c_rst = 1'b1;
    logic              c_wr_valid = 1'b0;
    logic [CAW-1:0]    c_wr_addr = '0;
    logic [CDW-1:0]    c_wr_data = '0;
    logic              c_rsv_valid = 1'b0;
    logic [CAW-1:0]    c_rsv_addr = '0;
    logic              c_flush = 1'b0;
    logic [CNR*CAW-1:0] c_rd_addr = '0;
    logic [CNR*CDW-1:0] c_rd_data;
    logic [CNR-1:0]     c_rd_busy;
    logic               c_rsv_ready;

    hsv_core_regfile_sb #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1)) dut_a (
        .clk_core(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .rsv_ready(a_rsv_ready), .flush(flush));

    hsv_core_regfile_sb #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0)) dut_b (
        .clk_core(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .rsv_ready(b_rsv_ready), .flush(flush));

    hsv_core_regfile_sb #(.DATA_W(CDW), .NUM_REGS(16), .NUM_RD(CNR), .BYPASS(1)) dut_c (
        .clk_core(clk), .rst(c_rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_valid(c_wr_valid), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rsv_valid(c_rsv_valid),
        .rsv_addr(c_rsv_addr), .rsv_ready(c_rsv_ready), .flush(c_flush));

    // Reference model: plain arrays updated by the architectural rules once per edge
    logic [63:0] m_mem [32];
    bit          m_busy [32];

    function automatic bit m_ready(bit fl, int ra, bit wv, int wa);
        return !fl && (ra == 0 || !m_busy[ra] || (wv && wa == ra));
    endfunction

    function automatic logic [63:0] m_rdata(int a, bit byp, bit wv, int wa, logic [63:0] wd);
        if (a == 0) return 64'd0;
        if (byp && wv && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic [63:0] m_rbusy(int a, bit byp, bit wv, int wa);
        if (a == 0) return 64'd0;
        if (byp && wv && wa == a) return 64'd0;
        return {63'd0, m_busy[a]};
    endfunction

    task automatic m_step(bit r, bit wv, int wa, logic [63:0] wd, bit rv, int ra, bit fl);
        bit ok;
        ok = m_ready(fl, ra, wv, wa);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 64'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wv && wa != 0) begin
                m_mem[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (fl) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (rv && ok && ra != 0) begin
                m_busy[ra] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ab_drive(input bit r, input bit wv, input int wa, input logic [31:0] wd,
                            input bit rv, input int ra, input bit fl, input int p0, input int p1);
        rst = r; wr_valid = wv; wr_addr = wa[AW-1:0]; wr_data = wd;
        rsv_valid = rv; rsv_addr = ra[AW-1:0]; flush = fl;
        rd_addr = {p1[AW-1:0], p0[AW-1:0]};
        #1;
        if (!r) begin
            chk("a_data0", {32'd0, a_rd_data[31:0]},  m_rdata(p0, 1'b1, wv, wa, {32'd0, wd}));
            chk("a_data1", {32'd0, a_rd_data[63:32]}, m_rdata(p1, 1'b1, wv, wa, {32'd0, wd}));
            chk("a_busy0", {63'd0, a_rd_busy[0]}, m_rbusy(p0, 1'b1, wv, wa));
            chk("a_busy1", {63'd0, a_rd_busy[1]}, m_rbusy(p1, 1'b1, wv, wa));
            chk("b_data0", {32'd0, b_rd_data[31:0]},  m_rdata(p0, 1'b0, wv, wa, {32'd0, wd}));
            chk("b_data1", {32'd0, b_rd_data[63:32]}, m_rdata(p1, 1'b0, wv, wa, {32'd0, wd}));
            chk("b_busy0", {63'd0, b_rd_busy[0]}, m_rbusy(p0, 1'b0, wv, wa));
            chk("b_busy1", {63'd0, b_rd_busy[1]}, m_rbusy(p1, 1'b0, wv, wa));
            chk("a_ready", {63'd0, a_rsv_ready}, {63'd0, m_ready(fl, ra, wv, wa)});
            chk("b_ready", {63'd0, b_rsv_ready}, {63'd0, m_ready(fl, ra, wv, wa)});
        end
    endtask

    task automatic ab_clk();
        @(posedge clk);
        m_step(rst, wr_valid, int'(wr_addr), {32'd0, wr_data}, rsv_valid, int'(rsv_addr), flush);
        #1;
    endtask

    task automatic c_drive(input bit r, input bit wv, input int wa, input logic [63:0] wd,
                           input bit rv, input int ra, input bit fl, input int p [CNR]);
        c_rst = r; c_wr_valid = wv; c_wr_addr = wa[CAW-1:0]; c_wr_data = wd;
        c_rsv_valid = rv; c_rsv_addr = ra[CAW-1:0]; c_flush = fl;
        for (int g = 0; g < CNR; g++) c_rd_addr[g*CAW +: CAW] = p[g][CAW-1:0];
        #1;
        if (!r) begin
            for (int g = 0; g < CNR; g++) begin
                chk($sformatf("c_data%0d", g), c_rd_data[g*CDW +: CDW], m_rdata(p[g], 1'b1, wv, wa, wd));
                chk($sformatf("c_busy%0d", g), {63'd0, c_rd_busy[g]}, m_rbusy(p[g], 1'b1, wv, wa));
            end
            chk("c_ready", {63'd0, c_rsv_ready}, {63'd0, m_ready(fl, ra, wv, wa)});
        end
    endtask

    task automatic c_clk();
        @(posedge clk);
        m_step(c_rst, c_wr_valid, int'(c_wr_addr), c_wr_data, c_rsv_valid, int'(c_rsv_addr), c_flush);
        #1;
    endtask

    initial begin
        int p [CNR];
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
        @(posedge clk); #1;

        // Reset and post-reset state
        ab_drive(1, 0, 0, 0, 0, 0, 0, 0, 0); ab_clk(); ab_clk();
        ab_drive(0, 0, 0, 0, 0, 5, 0, 3, 15);
        chk("reset_data", {32'd0, a_rd_data}, 64'd0);
        chk("reset_busy", {62'd0, a_rd_busy}, 64'd0);
        chk("reset_ready", {63'd0, a_rsv_ready}, 64'd1);
        ab_clk();

        // Basic write then dual-port read
        ab_drive(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0); ab_clk();
        ab_drive(0, 1, 15, 32'hCAFEBABE, 0, 0, 0, 0, 0); ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 3, 15);
        chk("x3_read", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);
        chk("x15_read", {32'd0, a_rd_data[63:32]}, 64'hCAFEBABE);
        chk("x3_x15_busy", {62'd0, a_rd_busy}, 64'd0);
        ab_clk();

        // Register 0 ignores writes and reservations
        ab_drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        chk("x0_ready", {63'd0, a_rsv_ready}, 64'd1);
        ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_data", {32'd0, a_rd_data[31:0]}, 64'd0);
        chk("x0_busy", {63'd0, a_rd_busy[0]}, 64'd0);
        ab_clk();

        // Double reservation refused; write-back plus re-reserve accepted
        ab_drive(0, 0, 0, 0, 1, 5, 0, 5, 0); ab_clk();
        ab_drive(0, 0, 0, 0, 1, 5, 0, 5, 0);
        chk("x5_refused", {63'd0, a_rsv_ready}, 64'd0);
        chk("x5_busy", {63'd0, a_rd_busy[0]}, 64'd1);
        ab_clk();
        ab_drive(0, 1, 5, 32'h12, 1, 5, 0, 0, 0);
        chk("x5_wb_accept", {63'd0, a_rsv_ready}, 64'd1);
        ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("x5_data", {32'd0, a_rd_data[31:0]}, 64'h12);
        chk("x5_still_busy", {63'd0, a_rd_busy[0]}, 64'd1);
        ab_clk();

        // Forwarding versus none
        ab_drive(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 7);
        chk("byp_data", {32'd0, a_rd_data[63:32]}, 64'hA5A5A5A5);
        chk("byp_busy", {63'd0, a_rd_busy[1]}, 64'd0);
        chk("nobyp_old", {32'd0, b_rd_data[63:32]}, 64'd0);
        ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
        chk("nobyp_new", {32'd0, b_rd_data[63:32]}, 64'hA5A5A5A5);
        ab_clk();

        // Flush drops reservations; concurrent write still lands
        ab_drive(0, 0, 0, 0, 1, 4, 0, 0, 0); ab_clk();
        ab_drive(0, 0, 0, 0, 1, 9, 0, 0, 0); ab_clk();
        ab_drive(0, 0, 0, 0, 1, 20, 0, 0, 0); ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 4, 9);
        chk("pre_flush_busy", {62'd0, a_rd_busy}, 64'd3);
        ab_clk();
        ab_drive(0, 1, 20, 32'h77, 1, 2, 1, 20, 2);
        chk("flush_ready", {63'd0, a_rsv_ready}, 64'd0);
        ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 4, 9);
        chk("flush_busy_4_9", {62'd0, a_rd_busy}, 64'd0);
        ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 20, 2);
        chk("flush_busy_20_2", {62'd0, a_rd_busy}, 64'd0);
        chk("flush_write", {32'd0, a_rd_data[31:0]}, 64'h77);
        ab_clk();

        // Reset mid-operation blocks a concurrent write and drops reservations
        ab_drive(0, 0, 0, 0, 1, 6, 0, 0, 0); ab_clk();
        ab_drive(1, 1, 6, 32'h99, 1, 8, 0, 0, 0); ab_clk();
        ab_drive(0, 0, 0, 0, 0, 0, 0, 6, 3);
        chk("rst_data", {32'd0, a_rd_data}, 64'd0);
        chk("rst_busy", {62'd0, a_rd_busy}, 64'd0);
        ab_clk();

        for (int i = 0; i < 80; i++) begin
            ab_drive(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                     1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15) == 0,
                     $urandom_range(0, 7), $urandom_range(0, 31));
            ab_clk();
        end

        // Wide 4-port instance: random traffic with resets mid-run
        for (int i = 0; i < 600; i++) begin
            for (int g = 0; g < CNR; g++) p[g] = $urandom_range(0, 15);
            c_drive((i < 2) || (i == 300) || ($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15) == 0, p);
            c_clk();
        end
        for (int g = 0; g < CNR; g++) p[g] = 0;
        c_drive(1, 1, 3, 64'h1, 1, 4, 0, p); c_clk();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < CNR; g++) p[g] = k * 4 + g;
            c_drive(0, 0, 0, 64'd0, 0, k * 4, 0, p);
            chk("c_rst_data", c_rd_data[127:0] | c_rd_data[255:128] ? 64'd1 : 64'd0, 64'd0);
            chk("c_rst_busy", {60'd0, c_rd_busy}, 64'd0);
            chk("c_rst_ready", {63'd0, c_rsv_ready}, 64'd1);
            c_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
